// File: rtl/circuito_jogo_sequencia_param.sv
// Sequence game: checks one-hot key presses against a fixed rotating pattern, with a
// selectable length (nivel), press-edge detection and a per-move timeout.
module circuito_jogo_sequencia_param #(
    parameter int unsigned N_CHAVES = 4,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned TIMEOUT  = 3000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_CHAVES-1:0] chaves,
    input  logic [ADDR_W-1:0]   nivel,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic                db_igual,
    output logic                db_iniciar,
    output logic [ADDR_W-1:0]   db_contagem,
    output logic [N_CHAVES-1:0] db_memoria,
    output logic [N_CHAVES-1:0] db_jogada,
    output logic [3:0]          db_estado
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        Inicial    = 4'h0,
        Preparacao = 4'h1,
        Espera     = 4'h2,
        Registra   = 4'h4,
        Compara    = 4'h5,
        Proximo    = 4'h6,
        FimAcertou = 4'hA,
        FimTimeout = 4'hD,
        FimErrou   = 4'hE
    } estado_t;

    estado_t             state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   limite_q, limite_d;
    logic [N_CHAVES-1:0] jogada_q, jogada_d;
    logic [N_CHAVES-1:0] chaves_ant_q;
    logic [TW-1:0]       tcnt_q, tcnt_d;

    logic [N_CHAVES-1:0] mem_dado;
    logic                jogada_valida;

    // Pattern ROM: a single bit walking through the key positions.
    assign mem_dado = N_CHAVES'(1) << (32'(addr_q) % N_CHAVES);

    // A press only counts on the transition from all-released to something pressed.
    assign jogada_valida = (chaves != '0) && (chaves_ant_q == '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        limite_d = limite_q;
        jogada_d = jogada_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            Inicial: begin
                if (iniciar) state_d = Preparacao;
            end
            Preparacao: begin
                addr_d   = '0;
                tcnt_d   = '0;
                jogada_d = '0;
                limite_d = nivel;
                state_d  = Espera;
            end
            Espera: begin
                tcnt_d = tcnt_q + TW'(1);
                if (jogada_valida) begin
                    state_d = Registra;
                end else if (tcnt_q == TLAST) begin
                    state_d = FimTimeout;
                end
            end
            Registra: begin
                jogada_d = chaves;
                state_d  = Compara;
            end
            Compara: begin
                if (jogada_q != mem_dado) begin
                    state_d = FimErrou;
                end else if (addr_q == limite_q) begin
                    state_d = FimAcertou;
                end else begin
                    state_d = Proximo;
                end
            end
            Proximo: begin
                addr_d  = addr_q + ADDR_W'(1);
                tcnt_d  = '0;
                state_d = Espera;
            end
            FimAcertou, FimErrou, FimTimeout: begin
                if (iniciar) state_d = Preparacao;
            end
            default: state_d = Inicial;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= Inicial;
            addr_q       <= '0;
            limite_q     <= '0;
            jogada_q     <= '0;
            chaves_ant_q <= '0;
            tcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            limite_q     <= limite_d;
            jogada_q     <= jogada_d;
            chaves_ant_q <= chaves;
            tcnt_q       <= tcnt_d;
        end
    end

    assign acertou     = (state_q == FimAcertou);
    assign errou       = (state_q == FimErrou);
    assign timeout     = (state_q == FimTimeout);
    assign pronto      = acertou | errou | timeout;
    assign db_igual    = (jogada_q == mem_dado);
    assign db_iniciar  = iniciar;
    assign db_contagem = addr_q;
    assign db_memoria  = mem_dado;
    assign db_jogada   = jogada_q;
    assign db_estado   = state_q;

endmodule

// File: tb/tb_circuito_jogo_sequencia_param.sv
// Randomized scoreboard bench for circuito_jogo_sequencia_param with a rule-level game model.
module tb_circuito_jogo_sequencia_param;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset, iniciar;
    logic [N-1:0]  chaves;
    logic [AW-1:0] nivel;
    logic          pronto, acertou, errou, timeout, db_igual, db_iniciar;
    logic [AW-1:0] db_contagem;
    logic [N-1:0]  db_memoria, db_jogada;
    logic [3:0]    db_estado;

    circuito_jogo_sequencia_param #(
        .N_CHAVES(N),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .chaves     (chaves),
        .nivel      (nivel),
        .pronto     (pronto),
        .acertou    (acertou),
        .errou      (errou),
        .timeout    (timeout),
        .db_igual   (db_igual),
        .db_iniciar (db_iniciar),
        .db_contagem(db_contagem),
        .db_memoria (db_memoria),
        .db_jogada  (db_jogada),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]    estado;
        logic [AW-1:0] addr;
        logic [N-1:0]  jog;
        logic [2:0]    flags;  // {acertou, errou, timeout}
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] keys[$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Game outcome from the rules: walk the presses against the pattern until one ends it.
    function automatic exp_t model(input int nv);
        exp_t e;
        e.estado = 4'hD;
        e.flags  = 3'b001;
        e.addr   = '0;
        e.jog    = '0;
        for (int i = 0; i < keys.size(); i++) begin
            e.addr = AW'(i);
            e.jog  = keys[i];
            if (keys[i] != N'(1 << (i % N))) begin
                e.estado = 4'hE;
                e.flags  = 3'b010;
                return e;
            end
            if (i == nv) begin
                e.estado = 4'hA;
                e.flags  = 3'b100;
                return e;
            end
        end
        e.addr = AW'(keys.size());
        return e;
    endfunction

    // Monitor: on every rising pronto, pop the expected outcome and compare.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (pronto && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_end", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("end_estado", 32'(db_estado), 32'(e.estado));
                    check("end_contagem", 32'(db_contagem), 32'(e.addr));
                    check("end_jogada", 32'(db_jogada), 32'(e.jog));
                    check("end_flags", 32'({acertou, errou, timeout}), 32'(e.flags));
                    check("end_memoria", 32'(db_memoria), 32'(1 << (e.addr % N)));
                    check("end_igual", 32'(db_igual), 32'(e.jog == N'(1 << (e.addr % N))));
                end
            end
            prev = pronto;
        end
    end

    // mode 0: hold then release; 1: maybe slide to a random nonzero value; 2: slide to 0010.
    task automatic press(input logic [N-1:0] k, input int mode, input bit term);
        chaves = k;
        @(posedge clock); #1;
        @(posedge clock); #1;
        if (term) check("lat_before_end", 32'(pronto), 32'd0);
        if (mode == 2) chaves = 4'b0010;
        else if (mode == 1 && $urandom_range(0, 1) == 1) chaves = N'($urandom_range(1, 15));
        @(posedge clock); #1;
        if (term) check("lat_at_end", 32'(pronto), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chaves = '0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic play(input int nv, input int mode);
        exp_t e;
        e = model(nv);
        sb.push_back(e);
        nivel   = AW'(nv);
        iniciar = 1'b1;
        #1;
        check("db_iniciar", 32'(db_iniciar), 32'd1);
        @(posedge clock); #1;
        iniciar = 1'b0;
        check("restart_flags_drop", 32'({pronto, acertou, errou, timeout}), 32'd0);
        check("estado_preparacao", 32'(db_estado), 32'h1);
        @(posedge clock); #1;
        nivel = AW'($urandom);
        for (int i = 0; i < keys.size(); i++) begin
            press(keys[i], mode, (i == keys.size() - 1) && (e.estado != 4'hD));
        end
        for (int c = 0; c < TO + 30 && !pronto; c++) begin
            @(posedge clock); #1;
        end
        check("end_reached", 32'(pronto), 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, kind, n;
        logic [N-1:0] bad, good;
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = '0;
        nivel   = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_estado", 32'(db_estado), 32'h0);
        check("reset_contagem", 32'(db_contagem), 32'd0);
        check("reset_flags", 32'({pronto, acertou, errou, timeout}), 32'd0);
        check("reset_jogada", 32'(db_jogada), 32'd0);

        // Full win
        keys.delete();
        keys.push_back(4'b0001); keys.push_back(4'b0010);
        keys.push_back(4'b0100); keys.push_back(4'b1000);
        play(3, 0);
        // Wrong second key
        keys.delete();
        keys.push_back(4'b0001); keys.push_back(4'b0100);
        play(3, 0);
        // Slide to the next key without release, then timeout
        keys.delete();
        keys.push_back(4'b0001);
        play(3, 2);
        // Multi-bit press on a single-move game, then a restart that wins
        keys.delete();
        keys.push_back(4'b1110);
        play(0, 0);
        keys.delete();
        keys.push_back(4'b0001);
        play(0, 0);

        // Reset mid-game with addr=2
        nivel   = 4'd3;
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        @(posedge clock); #1;
        press(4'b0001, 0, 1'b0);
        press(4'b0010, 0, 1'b0);
        check("mid_estado", 32'(db_estado), 32'h2);
        check("mid_contagem", 32'(db_contagem), 32'd2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset_estado", 32'(db_estado), 32'h0);
        check("midreset_contagem", 32'(db_contagem), 32'd0);
        check("midreset_flags", 32'({pronto, acertou, errou, timeout}), 32'd0);
        check("midreset_jogada", 32'(db_jogada), 32'd0);

        repeat (30) begin
            nv   = $urandom_range(0, 15);
            kind = $urandom_range(0, 2);
            n    = (kind == 0) ? nv + 1 : $urandom_range(0, nv);
            keys.delete();
            for (int i = 0; i < n; i++) keys.push_back(N'(1 << (i % N)));
            if (kind == 1) begin
                good = N'(1 << (n % N));
                bad  = N'($urandom_range(1, 15));
                while (bad == good) bad = N'($urandom_range(1, 15));
                keys.push_back(bad);
            end
            play(nv, 1);
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
